// File: rtl/uart_tx_engine.sv
// UART transmit engine: accepts a word, requests the line via tx_rts_n/tx_cts_n,
// then serialises start, LSB-first data, optional parity and stop bit(s).
module uart_tx_engine #(
    parameter int CLK_DIV    = 16,
    parameter int DATA_W     = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int CTS_TO     = 1024
) (
    input  logic              tck,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic              tx_rts_n,
    input  logic              tx_cts_n,
    input  logic              tx_enable,
    output logic              tx,
    output logic              busy_o,
    output logic              cts_to_o
);

    localparam int BAUD_W = $clog2(CLK_DIV);
    localparam int TO_W   = (CTS_TO > 1) ? $clog2(CTS_TO) : 1;
    localparam int BIT_W  = $clog2(DATA_W);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(CTS_TO - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_BACKOFF, S_START, S_DATA, S_PARITY, S_STOP, S_DONE
    } state_t;

    state_t              state, state_n;
    logic [BAUD_W-1:0]   baud_cnt, baud_n;
    logic [BIT_W-1:0]    bit_cnt, bit_n;
    logic [TO_W-1:0]     to_cnt, to_n;
    logic [DATA_W-1:0]   shreg, shreg_n;
    logic                par, par_n;
    logic                tx_n, rts_n_n, cto_n;
    logic                bit_end, grant;

    assign ready_o = (state == S_IDLE);
    assign bit_end = (baud_cnt == BAUD_LAST);
    assign grant   = !tx_cts_n && tx_enable;

    always_comb begin
        state_n = state;
        baud_n  = baud_cnt;
        bit_n   = bit_cnt;
        to_n    = to_cnt;
        shreg_n = shreg;
        par_n   = par;
        cto_n   = 1'b0;

        if (state inside {S_START, S_DATA, S_PARITY, S_STOP})
            baud_n = bit_end ? '0 : baud_cnt + 1'b1;

        case (state)
            S_IDLE: begin
                if (valid_i) begin
                    shreg_n = data_i;
                    par_n   = (^data_i) ^ (PARITY_ODD != 0);
                    to_n    = '0;
                    state_n = S_REQ;
                end
            end
            S_REQ: begin
                // A grant in the final timeout cycle still wins over the retry.
                if (grant) begin
                    baud_n  = '0;
                    bit_n   = '0;
                    state_n = S_START;
                end else if (to_cnt == TO_LAST) begin
                    cto_n   = 1'b1;
                    state_n = S_BACKOFF;
                end else begin
                    to_n = to_cnt + 1'b1;
                end
            end
            S_BACKOFF: begin
                to_n    = '0;
                state_n = S_REQ;
            end
            S_START: begin
                if (bit_end) state_n = S_DATA;
            end
            S_DATA: begin
                if (bit_end) begin
                    shreg_n = shreg >> 1;
                    if (bit_cnt == DATA_LAST) begin
                        bit_n   = '0;
                        state_n = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_n = bit_cnt + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) state_n = S_STOP;
            end
            S_STOP: begin
                if (bit_end) begin
                    if (bit_cnt == STOP_LAST) begin
                        bit_n   = '0;
                        state_n = S_DONE;
                    end else begin
                        bit_n = bit_cnt + 1'b1;
                    end
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase

        // Line outputs are registered from the next state so they change with it.
        case (state_n)
            S_START:  tx_n = 1'b0;
            S_DATA:   tx_n = shreg_n[0];
            S_PARITY: tx_n = par_n;
            default:  tx_n = 1'b1;
        endcase
        rts_n_n = !(state_n inside {S_REQ, S_START, S_DATA, S_PARITY, S_STOP});
    end

    always_ff @(posedge tck) begin
        if (rst) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            to_cnt   <= '0;
            shreg    <= '0;
            par      <= 1'b0;
            tx       <= 1'b1;
            tx_rts_n <= 1'b1;
            busy_o   <= 1'b0;
            cts_to_o <= 1'b0;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_cnt  <= bit_n;
            to_cnt   <= to_n;
            shreg    <= shreg_n;
            par      <= par_n;
            tx       <= tx_n;
            tx_rts_n <= rts_n_n;
            busy_o   <= (state_n != S_IDLE);
            cts_to_o <= cto_n;
        end
    end

endmodule
